// File: rtl/coeff_block_writer.sv
// Dequantises zigzag-ordered coefficients and writes them, in raster order,
// into the pre-IDCT region of SRAM for a full Y/U/V frame of 8x8 blocks.
module coeff_block_writer #(
    parameter logic [17:0] PREIDCT_BASE  = 18'd76800,
    parameter int unsigned Y_BLOCK_COLS  = 40,
    parameter int unsigned UV_BLOCK_COLS = 20,
    parameter int unsigned BLOCK_ROWS    = 30
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Q_sel,
    input  logic        In_valid,
    input  logic [15:0] In_coeff,
    output logic        In_ready,
    input  logic        SRAM_grant,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        Block_done,
    output logic        Done
);

    localparam int unsigned Y_W      = 8 * Y_BLOCK_COLS;
    localparam int unsigned UV_W     = 8 * UV_BLOCK_COLS;
    localparam int unsigned U_OFF    = 8 * BLOCK_ROWS * Y_W;
    localparam int unsigned V_OFF    = U_OFF + 8 * BLOCK_ROWS * UV_W;
    localparam int unsigned MAX_COLS = (Y_BLOCK_COLS > UV_BLOCK_COLS) ? Y_BLOCK_COLS : UV_BLOCK_COLS;
    localparam int unsigned COLW     = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam int unsigned ROWW     = (BLOCK_ROWS > 1) ? $clog2(BLOCK_ROWS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t            state;
    logic [5:0]        k;
    logic [COLW-1:0]   bcol;
    logic [ROWW-1:0]   brow;
    logic [1:0]        plane;
    logic              q_hold;
    logic              final_wr;

    logic              handshake;
    logic              q_eff;
    logic              last_col;
    logic              last_row;
    logic              last_block;
    logic [5:0]        zz;
    logic [2:0]        zz_row;
    logic [2:0]        zz_col;
    logic [3:0]        diag;
    logic [2:0]        shamt;
    logic [22:0]       scaled;
    logic [15:0]       sat_data;
    logic [31:0]       width;
    logic [31:0]       plane_off;
    logic [31:0]       line;
    logic [17:0]       addr_full;

    always_comb begin
        In_ready  = (state == ST_RUN) && SRAM_grant;
        handshake = In_valid && In_ready;
        q_eff     = (k == 6'd0) ? Q_sel : q_hold;
    end

    // Zigzag index -> raster position (row in [5:3], column in [2:0])
    always_comb begin
        zz = '0;
        case (k)
            6'd0:  zz = 6'd0;  6'd1:  zz = 6'd1;  6'd2:  zz = 6'd8;  6'd3:  zz = 6'd16; 6'd4:  zz = 6'd9;  6'd5:  zz = 6'd2;  6'd6:  zz = 6'd3;  6'd7:  zz = 6'd10;
            6'd8:  zz = 6'd17; 6'd9:  zz = 6'd24; 6'd10: zz = 6'd32; 6'd11: zz = 6'd25; 6'd12: zz = 6'd18; 6'd13: zz = 6'd11; 6'd14: zz = 6'd4;  6'd15: zz = 6'd5;
            6'd16: zz = 6'd12; 6'd17: zz = 6'd19; 6'd18: zz = 6'd26; 6'd19: zz = 6'd33; 6'd20: zz = 6'd40; 6'd21: zz = 6'd48; 6'd22: zz = 6'd41; 6'd23: zz = 6'd34;
            6'd24: zz = 6'd27; 6'd25: zz = 6'd20; 6'd26: zz = 6'd13; 6'd27: zz = 6'd6;  6'd28: zz = 6'd7;  6'd29: zz = 6'd14; 6'd30: zz = 6'd21; 6'd31: zz = 6'd28;
            6'd32: zz = 6'd35; 6'd33: zz = 6'd42; 6'd34: zz = 6'd49; 6'd35: zz = 6'd56; 6'd36: zz = 6'd57; 6'd37: zz = 6'd50; 6'd38: zz = 6'd43; 6'd39: zz = 6'd36;
            6'd40: zz = 6'd29; 6'd41: zz = 6'd22; 6'd42: zz = 6'd15; 6'd43: zz = 6'd23; 6'd44: zz = 6'd30; 6'd45: zz = 6'd37; 6'd46: zz = 6'd44; 6'd47: zz = 6'd51;
            6'd48: zz = 6'd58; 6'd49: zz = 6'd59; 6'd50: zz = 6'd52; 6'd51: zz = 6'd45; 6'd52: zz = 6'd38; 6'd53: zz = 6'd31; 6'd54: zz = 6'd39; 6'd55: zz = 6'd46;
            6'd56: zz = 6'd53; 6'd57: zz = 6'd60; 6'd58: zz = 6'd61; 6'd59: zz = 6'd54; 6'd60: zz = 6'd47; 6'd61: zz = 6'd55; 6'd62: zz = 6'd62; 6'd63: zz = 6'd63;
            default: zz = '0;
        endcase
        zz_row = zz[5:3];
        zz_col = zz[2:0];
        diag   = {1'b0, zz_row} + {1'b0, zz_col};
    end

    always_comb begin
        shamt = 3'd3;
        if (!q_eff) begin
            if (diag == 4'd0)       shamt = 3'd3;
            else if (diag == 4'd1)  shamt = 3'd2;
            else if (diag <= 4'd3)  shamt = 3'd3;
            else if (diag <= 4'd5)  shamt = 3'd4;
            else if (diag <= 4'd7)  shamt = 3'd5;
            else                    shamt = 3'd6;
        end else begin
            if (diag == 4'd0)       shamt = 3'd3;
            else if (diag <= 4'd3)  shamt = 3'd1;
            else if (diag <= 4'd5)  shamt = 3'd2;
            else if (diag <= 4'd7)  shamt = 3'd3;
            else                    shamt = 3'd4;
        end
    end

    // Sign-extended product fits 23 bits; it is in range when bits 22..15 agree
    always_comb begin
        scaled = {{7{In_coeff[15]}}, In_coeff} << shamt;
        if (scaled[22:15] == '0 || scaled[22:15] == '1)
            sat_data = scaled[15:0];
        else if (scaled[22])
            sat_data = 16'h8000;
        else
            sat_data = 16'h7FFF;
    end

    always_comb begin
        width     = (plane == 2'd0) ? 32'(Y_W) : 32'(UV_W);
        plane_off = (plane == 2'd0) ? '0 : (plane == 2'd1) ? 32'(U_OFF) : 32'(V_OFF);
        line      = 32'({brow, 3'b000}) + 32'(zz_row);
        addr_full = 18'(32'(PREIDCT_BASE) + plane_off + line * width
                        + 32'({bcol, 3'b000}) + 32'(zz_col));
        last_col  = (plane == 2'd0) ? (bcol == COLW'(Y_BLOCK_COLS - 1))
                                    : (bcol == COLW'(UV_BLOCK_COLS - 1));
        last_row  = (brow == ROWW'(BLOCK_ROWS - 1));
        last_block = (k == 6'd63) && last_col && last_row && (plane == 2'd2);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state           <= ST_IDLE;
            k               <= '0;
            bcol            <= '0;
            brow            <= '0;
            plane           <= '0;
            q_hold          <= 1'b0;
            final_wr        <= 1'b0;
            SRAM_we_n       <= 1'b1;
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            Block_done      <= 1'b0;
            Done            <= 1'b0;
        end else begin
            SRAM_we_n  <= !handshake;
            Block_done <= handshake && (k == 6'd63);
            final_wr   <= handshake && last_block;
            if (handshake) begin
                SRAM_address    <= addr_full;
                SRAM_write_data <= sat_data;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        state <= ST_RUN;
                        k     <= '0;
                        bcol  <= '0;
                        brow  <= '0;
                        plane <= '0;
                        Done  <= 1'b0;
                    end else if (final_wr) begin
                        Done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (handshake) begin
                        if (k == 6'd0)
                            q_hold <= Q_sel;
                        if (k == 6'd63) begin
                            k <= '0;
                            if (last_col) begin
                                bcol <= '0;
                                if (last_row) begin
                                    brow  <= '0;
                                    plane <= plane + 2'd1;
                                end else begin
                                    brow <= brow + ROWW'(1);
                                end
                            end else begin
                                bcol <= bcol + COLW'(1);
                            end
                            // Leave RUN at the final handshake so no extra coefficient is accepted
                            if (last_block)
                                state <= ST_DONE;
                        end else begin
                            k <= k + 6'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/coeff_block_writer.md
COEFF_BLOCK_WRITER -- requirements
Module: coeff_block_writer

Interface
REQ-001 Parameter PREIDCT_BASE, default 18'd76800, SHALL set the SRAM word address of Y block (0,0) coefficient (0,0).
REQ-002 Parameter Y_BLOCK_COLS, default 40, SHALL set the number of Y blocks per block row.
REQ-003 Parameter UV_BLOCK_COLS, default 20, SHALL set the number of U/V blocks per block row.
REQ-004 Parameter BLOCK_ROWS, default 30, SHALL set the number of block rows per plane.
REQ-005 Clock  in  1  SHALL be the single clock; all state changes on the rising edge.
REQ-006 Reset  in  1  SHALL be a synchronous, active-high reset.
REQ-007 Start  in  1  SHALL be a one-cycle pulse that begins a frame of 2400 blocks; it is ignored unless state is IDLE or DONE.
REQ-008 Q_sel  in  1  SHALL select the dequantisation matrix; it is sampled at coefficient 0 of each block and held for that block.
REQ-009 In_valid  in  1  SHALL qualify In_coeff.
REQ-010 In_coeff  in  16  SHALL carry a signed quantised coefficient, in zigzag order, 64 per block.
REQ-011 In_ready  out  1  SHALL equal (state==RUN) && SRAM_grant.
REQ-012 SRAM_grant  in  1  SHALL indicate that this block owns the SRAM port this cycle.
REQ-013 SRAM_address  out  18  SHALL be the write word address.
REQ-014 SRAM_write_data  out  16  SHALL be the dequantised coefficient.
REQ-015 SRAM_we_n  out  1  SHALL be an active-low write strobe.
REQ-016 Block_done  out  1  SHALL pulse high for one cycle in the cycle that coefficient 63 of any block is written.
REQ-017 Done  out  1  SHALL go high after the last write of block 2399 and hold until Start or Reset.

Function
REQ-018 States SHALL be IDLE, RUN and DONE. Start moves IDLE/DONE->RUN and clears all counters and Done. The write of coefficient 63 of block 2399 moves RUN->DONE.
REQ-019 A handshake SHALL be In_valid && In_ready; exactly one coefficient is consumed per handshake.
REQ-020 The write SHALL occur in the cycle after its handshake: SRAM_we_n=0, with registered address and data. SRAM_we_n SHALL be 1 in every cycle not following a handshake.
REQ-021 Zigzag index k (0..63) SHALL map to (row,col) per the standard JPEG zigzag: 0:(0,0), 1:(0,1), 2:(1,0), 3:(2,0), 4:(1,1), 5:(0,2), 6:(0,3), 7:(1,2) ... 63:(7,7).
REQ-022 Dequantisation SHALL be In_coeff arithmetically shifted left by shift(row+col), saturated to [-32768, 32767].
REQ-023 With Q_sel=0, shift SHALL be: s=0:3, 1:2, 2-3:3, 4-5:4, 6-7:5, s>=8:6.
REQ-024 With Q_sel=1, shift SHALL be: s=0:3, 1-3:1, 4-5:2, 6-7:3, s>=8:4.
REQ-025 Plane order SHALL be Y (blocks 0-1199), U (1200-1799), V (1800-2399), with blocks raster-ordered within each plane.
REQ-026 Row width W SHALL be 8*Y_BLOCK_COLS=320 for Y and 8*UV_BLOCK_COLS=160 for U/V.
REQ-027 Plane offsets SHALL be Y=0, U=76800 and V=115200.
REQ-028 Address SHALL be PREIDCT_BASE + plane_off + (8*brow+row)*W + 8*bcol + col.
REQ-029 Block counters SHALL advance on coefficient 63: k wraps to 0 and bcol increments.
REQ-030 When bcol reaches the last column of its plane, bcol SHALL return to 0 and brow SHALL increment.
REQ-031 When brow reaches 29, brow SHALL return to 0 and the plane SHALL advance.
REQ-032 Deasserted SRAM_grant or In_valid SHALL stall without losing or duplicating coefficients. All counters SHALL hold.
REQ-033 Start arriving during RUN SHALL have no effect.

Reset
REQ-034 On Reset the following SHALL be set: state=IDLE, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, In_ready=0, Block_done=0, Done=0, and all counters 0.
REQ-035 Reset asserted mid-frame SHALL abort the frame and suppress any pending write (SRAM_we_n=1 in the next cycle). A later Start SHALL restart at block 0.

Verification
REQ-036 Start, then 64 coefficients of value 1 with Q_sel=0 and continuous valid/grant. Required: writes to 76800 (data 8), 76801 (data 4), 77120 (data 4); coefficient 63 goes to 76800+7*320+7=79047 with data 64; Block_done pulses once.
REQ-037 Block 40 (first block of Y block row 1). Required: coefficient 0 is written to address 76800+8*320=79360.
REQ-038 Blocks 1200 and 1800, coefficient 0. Required: writes to 153600 and 192000. Block 1219 coefficient 63 is written to 153600+7*160+159=154879.
REQ-039 In_coeff=16'h7FFF at k=0 with Q_sel=0. Required: data 16'h7FFF. In_coeff=16'h8000 at k=0. Required: data 16'h8000. In_coeff=-3 at k=1 with Q_sel=1. Required: data -6.
REQ-040 Toggle SRAM_grant and In_valid randomly across a full frame. Required: exactly 153600 writes with no address repeated; Done rises after the write to 230399.
REQ-041 Assert Reset one cycle after a handshake at k=10. Required: SRAM_we_n=1 in the next cycle and state=IDLE. Start again. Required: first write at 76800.
